// File: rtl/ivector_driver_pkg.sv
// ivector_driver_pkg
//   Shared widths, payload type and FSM state encodings for the IVector
//   say/heard echo driver.
//   Contents:
//     METH_W, V_W, PAY_W  field widths of one say/heard transaction
//     ivec_payload_t      packed {v, meth} transaction payload
//     S_IDLE..S_DONE      driver FSM state encodings
//     makePayload()       builds a payload from separate meth/v fields
package ivector_driver_pkg;

    localparam int METH_W = 6;
    localparam int V_W    = 4;
    localparam int PAY_W  = METH_W + V_W;

    typedef struct packed {
        logic [V_W-1:0]    v;
        logic [METH_W-1:0] meth;
    } ivec_payload_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic ivec_payload_t makePayload(input logic [METH_W-1:0] meth,
                                                  input logic [V_W-1:0]    v);
        ivec_payload_t p;
        p.meth = meth;
        p.v    = v;
        return p;
    endfunction

endpackage

// File: rtl/ivector_driver_if.sv
// ivector_driver_if
//   Say/heard echo bus between the driver (master) and the echo block (slave).
//   Signals:
//     say_ENA/say_meth/say_v      master -> slave, one say transfer when ENA=1
//     say_RDY                     slave  -> master, echo block can accept a say
//     heard_ENA/heard_meth/heard_v slave -> master, one heard transfer when ENA=1
//     heard_RDY                   master -> slave, driver can accept a heard
interface ivector_driver_if;
    import ivector_driver_pkg::*;

    logic              say_ENA;
    logic [METH_W-1:0] say_meth;
    logic [V_W-1:0]    say_v;
    logic              say_RDY;

    logic              heard_ENA;
    logic [METH_W-1:0] heard_meth;
    logic [V_W-1:0]    heard_v;
    logic              heard_RDY;

    modport master (
        output say_ENA, say_meth, say_v,
        input  say_RDY,
        input  heard_ENA, heard_meth, heard_v,
        output heard_RDY
    );

    modport slave (
        input  say_ENA, say_meth, say_v,
        output say_RDY,
        output heard_ENA, heard_meth, heard_v,
        input  heard_RDY
    );

endinterface

// File: rtl/ivector_driver_expect_fifo.sv
// ivector_driver_expect_fifo
//   Queue of expected {v,meth} payloads for says issued but not yet heard.
//   Ports:
//     CLK, nRST     clock, synchronous active-low reset (empties the queue)
//     i_enq         push i_enq_data (ignored when full)
//     o_enq_rdy     queue not full
//     i_deq         pop head (ignored when empty)
//     o_first       head entry
//     o_deq_rdy     queue not empty
//     o_count       current occupancy, 0..DEPTH
module ivector_driver_expect_fifo
    import ivector_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     i_enq,
    input  ivec_payload_t            i_enq_data,
    output logic                     o_enq_rdy,
    input  logic                     i_deq,
    output ivec_payload_t            o_first,
    output logic                     o_deq_rdy,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    ivec_payload_t   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_enq;
    logic            w_deq;

    assign o_enq_rdy = (r_count != FULL);
    assign o_deq_rdy = (r_count != '0);
    assign o_first   = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign w_enq     = i_enq && o_enq_rdy;
    assign w_deq     = i_deq && o_deq_rdy;

    // DEPTH is a power of two, so the pointers wrap naturally.
    // A full queue refuses a push even when a pop lands in the same cycle.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                r_mem[r_wr_ptr] <= i_enq_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ivector_driver.sv
// ivector_driver
//   Issues a burst of say transactions to an echo block and checks the
//   returning heard indications, in order, against the payloads it sent.
//   Ports:
//     CLK, nRST       clock, synchronous active-low reset
//     i_start_ENA     begin a burst (accepted only when o_start_RDY=1)
//     i_start_count   number of transactions in the burst
//     o_start_RDY     high in IDLE and DONE
//     bus             say/heard echo bus (master side)
//     o_done          burst complete
//     o_match_count   heard entries equal to expected
//     o_error_count   heard entries differing from expected
//     o_err_first     {v,meth} of the first mismatching heard, 0 if none
module ivector_driver
    import ivector_driver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 9
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_start_ENA,
    input  logic [CNT_W-1:0]  i_start_count,
    output logic              o_start_RDY,
    ivector_driver_if.master  bus,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_match_count,
    output logic [CNT_W-1:0]  o_error_count,
    output logic [PAY_W-1:0]  o_err_first
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_issue_idx;
    logic [CNT_W-1:0] r_heard_idx;
    logic [CNT_W-1:0] r_match;
    logic [CNT_W-1:0] r_error;
    ivec_payload_t    r_err_first;

    logic             w_start_acc;
    logic             w_say_ena;
    logic             w_heard_fire;
    logic             w_enq_rdy;
    logic             w_deq_rdy;
    logic [OCC_W-1:0] w_outstanding;
    logic [CNT_W-1:0] w_issue_next;
    logic [CNT_W-1:0] w_heard_next;
    ivec_payload_t    w_issue_pay;
    ivec_payload_t    w_heard_pay;
    ivec_payload_t    w_expect;

    assign o_start_RDY   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign o_done        = (r_state == S_DONE);
    assign o_match_count = r_match;
    assign o_error_count = r_error;
    assign o_err_first   = r_err_first;

    assign w_start_acc  = i_start_ENA && o_start_RDY;
    assign w_issue_next = r_issue_idx + 1'b1;
    assign w_heard_next = r_heard_idx + 1'b1;

    // Payload is derived from the issue index so the echo return can be
    // checked without storing the burst contents anywhere else.
    assign w_issue_pay = makePayload(r_issue_idx[METH_W-1:0], ~r_issue_idx[V_W-1:0]);
    assign w_heard_pay = makePayload(bus.heard_meth, bus.heard_v);

    // Issue is gated on queue space as seen at the start of the cycle, so a
    // pop in the same cycle never frees a slot early.
    assign w_say_ena    = (r_state == S_RUN) && bus.say_RDY &&
                          (r_issue_idx < r_count) && w_enq_rdy;
    assign bus.say_ENA  = w_say_ena;
    assign bus.say_meth = w_issue_pay.meth;
    assign bus.say_v    = w_issue_pay.v;

    // A heard arriving with nothing outstanding is the peer's fault and is dropped.
    assign bus.heard_RDY = (w_outstanding != '0);
    assign w_heard_fire  = bus.heard_ENA && w_deq_rdy;

    ivector_driver_expect_fifo #(
        .DEPTH (DEPTH)
    ) u_expect (
        .CLK        (CLK),
        .nRST       (nRST),
        .i_enq      (w_say_ena),
        .i_enq_data (w_issue_pay),
        .o_enq_rdy  (w_enq_rdy),
        .i_deq      (w_heard_fire),
        .o_first    (w_expect),
        .o_deq_rdy  (w_deq_rdy),
        .o_count    (w_outstanding)
    );

    // Burst sequencing: a zero-length burst goes straight to DONE; RUN ends on
    // the cycle the last say issues and DRAIN ends on the cycle the last heard lands.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_issue_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start_ENA) begin
                        r_count     <= i_start_count;
                        r_issue_idx <= '0;
                        r_state     <= (i_start_count == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_say_ena) begin
                        r_issue_idx <= w_issue_next;
                        if (w_issue_next == r_count) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_heard_fire && (w_heard_next == r_count)) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result bookkeeping: counters wrap; only the first mismatch is captured.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_heard_idx <= '0;
            r_match     <= '0;
            r_error     <= '0;
            r_err_first <= '0;
        end else if (w_start_acc) begin
            r_heard_idx <= '0;
            r_match     <= '0;
            r_error     <= '0;
            r_err_first <= '0;
        end else if (w_heard_fire) begin
            r_heard_idx <= w_heard_next;
            if (w_heard_pay == w_expect) begin
                r_match <= r_match + 1'b1;
            end else begin
                r_error <= r_error + 1'b1;
                if (r_error == '0) begin
                    r_err_first <= w_heard_pay;
                end
            end
        end
    end

endmodule
